matrix_operand_loader: RTL
==========================

# matrix_operand_loader

Upstream fetch stage for the systolic matrix-multiply core. On a start pulse it reads 2·N·N words from memory over the single-word request/done handshake and packs the low W bits of each into one flat operand bus: A in the lower half, B in the upper half, row-major. It presents the bus with a valid/ack handshake to the multiply control block. It owns all operand-load memory traffic, so the multiply stage only sees a complete, stable operand set.

## Interface
Parameters:
- W, 16, operand element width (bits taken from each memory word)
- N, 3, matrix dimension; loads 2·N·N words
- TIMEOUT, 255, maximum FETCH cycles per word before abort (used only with LOAD_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE
- base_addr  in  32  byte address of word 0; captured on accepted start
- busy  out  1  high in every state except IDLE
- mem_req  out  1  memory read request (level)
- mem_addr  out  32  read address, stable while mem_req high
- mem_done  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  32  read data
- operands  out  2·W·N·N  packed operands; word k at bits [k·W +: W]
- operands_valid  out  1  operands complete and stable
- operands_ack  in  1  consumer has taken operands
- err  out  1  one-cycle abort pulse

## Operation
- States: IDLE, FETCH, GAP, HOLD. A word index k runs 0..2·N·N−1.
- IDLE: busy=0, mem_req=0. When start=1, capture base_addr, set k=0, and go to FETCH.
- FETCH: mem_req=1 and mem_addr=base+4·k, using 32-bit modular wrap with no carry-out.
  - When mem_done=1, write mem_rdata[W−1:0] into operands[k·W +: W].
  - If k=2·N·N−1, go to HOLD. Otherwise set k=k+1 and go to GAP.
- GAP: mem_req=0 for exactly one cycle, then go to FETCH.
- HOLD: operands_valid=1 and operands is frozen. When operands_ack=1, go to IDLE; operands_valid drops in the next cycle.
- Words 0..N·N−1 form A and words N·N..2·N·N−1 form B. Element (r,c) is word r·N+c within its half.
- Ignored inputs:
  - mem_done outside FETCH.
  - operands_ack outside HOLD.
  - start outside IDLE, including start pulses that arrive during HOLD.
- operands is not cleared on a new start; each word is overwritten as it is fetched.
- mem_rdata[31:W] is discarded.

## Timing
- Reset (async, any state) drives: state=IDLE, k=0, busy=0, mem_req=0, mem_addr=0, operands=0, operands_valid=0, err=0. Release is synchronous to clk.
- Any load in progress is abandoned on reset. No partial handshake survives.
- All outputs are registered.
- start is sampled at edge E0, and FETCH for word 0 begins in the cycle after E0.
- Zero-wait memory (mem_done high in the first FETCH cycle of each word) costs 2 cycles per word. operands_valid rises 4·N·N cycles after E0, which is 36 cycles for N=3.
- Each wait cycle on mem_done adds one cycle.
- mem_done and operands_ack may be held high continuously. Each is consumed at most once per FETCH visit or HOLD visit respectively.
- Back-to-back loads are possible: if start is high in the cycle after HOLD exits, it is accepted in that IDLE cycle.

## Configuration
- Macro: LOAD_TIMEOUT_EN.
- With LOAD_TIMEOUT_EN defined:
  - A per-word cycle counter clears on every FETCH entry.
  - If TIMEOUT consecutive FETCH cycles pass without mem_done, the block goes to IDLE, pulses err for one cycle, and drops mem_req.
  - operands keeps its partially written contents and operands_valid stays 0.
- Without LOAD_TIMEOUT_EN: FETCH waits indefinitely, err is tied to 0, and no counter is built.

## Test plan
- Reset: assert rst_n=0 mid-FETCH on word 5 → mem_req, busy and operands_valid go to 0 immediately (async). After release the block is in IDLE and operands=0.
- Zero-wait load: base_addr=0x100, memory returns word k = 0xABCD0000|(k+1) → addresses 0x100..0x144 in steps of 4. operands_valid rises 36 cycles after start. A(0,0)=0x0001, B(2,2)=0x0012.
- Waits and ack: 3 wait cycles on every word, and operands_ack delayed 10 cycles → operands_valid rises at cycle 90 and stays high with operands stable until ack, then drops one cycle later. A start pulse during HOLD is ignored.
- Address wrap: base_addr=0xFFFFFFF8 → word 2 address is 0x00000000. Operands are packed correctly.
- Timeout (LOAD_TIMEOUT_EN, TIMEOUT=8): memory never answers word 4 → err pulses once 8 cycles after FETCH entry, the block returns to IDLE, and operands_valid stays 0. Without the macro, mem_req stays high for 1000 cycles and err stays 0.

Source files
------------

// File: rtl/matrix_operand_loader.sv
// Operand fetch stage: loads 2*N*N words over a request/done handshake and packs their low W bits
// into one flat bus (A in the low half, B in the high half). Optional macro: LOAD_TIMEOUT_EN.
module matrix_operand_loader #(
  parameter int W       = 16,
  parameter int N       = 3,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        base_addr,
  output logic               busy,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_done,
  input  logic [31:0]        mem_rdata,
  output logic [2*W*N*N-1:0] operands,
  output logic               operands_valid,
  input  logic               operands_ack,
  output logic               err
);

  localparam int NWORDS = 2 * N * N;
  localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int OPW    = NWORDS * W;
  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_GAP   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [KW-1:0]   r_k, w_k_nxt;
  logic [31:0]     r_addr, w_addr_nxt;
  logic [OPW-1:0]  r_operands;
  logic            r_busy, r_mem_req, r_valid;
  logic            w_wr;
  logic            w_abort;
  logic            w_unused_rdata;

  assign w_unused_rdata = ^mem_rdata[31:W];

`ifdef LOAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_tcnt;
  logic          r_err;

  assign w_abort = (r_state == S_FETCH) && !mem_done && (r_tcnt == CW'(TIMEOUT - 1));
  assign err     = r_err;

  // per-word wait counter: zero outside FETCH, so every FETCH entry starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (w_state_nxt != S_FETCH || r_state != S_FETCH) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + CW'(1);
      end
    end
  end
`else
  localparam int unused_timeout_p = TIMEOUT;
  assign w_abort = 1'b0;
  assign err     = 1'b0;
`endif

  // state, index and address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_addr  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // next-state decode; mem_done/ack/start only matter in their own state
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_addr_nxt  = r_addr;
    w_wr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_k_nxt     = '0;
          w_addr_nxt  = base_addr;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (mem_done) begin
          w_wr = 1'b1;
          if (r_k == K_LAST) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_GAP;
            w_k_nxt     = r_k + KW'(1);
            w_addr_nxt  = r_addr + 32'd4;
          end
        end else if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_GAP: begin
        w_state_nxt = S_FETCH;
      end
      S_HOLD: begin
        if (operands_ack) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // outputs registered from the next state so they line up with the state itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_valid    <= 1'b0;
      r_operands <= '0;
    end else begin
      r_busy    <= (w_state_nxt != S_IDLE);
      r_mem_req <= (w_state_nxt == S_FETCH);
      r_valid   <= (w_state_nxt == S_HOLD);
      if (w_wr) begin
        r_operands[r_k*W +: W] <= mem_rdata[W-1:0];
      end
    end
  end

  assign busy           = r_busy;
  assign mem_req        = r_mem_req;
  assign mem_addr       = r_addr;
  assign operands       = r_operands;
  assign operands_valid = r_valid;

endmodule
